div_iter: RTL

Iterative radix-2 restoring divider for the 5-stage MIPS core. It is the responder side of the EX-stage divide handshake: EX holds `start_i` with latched operands while it stalls the pipeline, and this block returns `{remainder, quotient}` with a `ready_o` pulse. It serves DIV and DIVU. Results are written to HI (remainder) and LO (quotient) by the issuing instruction.

---
 rtl/div_iter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} with a ready pulse, 33 cycles after the start request.
module div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W:0]     work_q, work_d;
   logic [W-1:0]     dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [2*W-1:0]   result_q, result_d;
   logic             ready_q, ready_d;

   logic [W-1:0]     a_mag, b_mag;
   logic [W+1:0]     trial;
   logic [2*W:0]     step;
   logic [W-1:0]     quot, rem;

   // Operand magnitudes, computed from the live inputs for latching in IDLE
   always_comb begin
      a_mag = opdata1_i;
      b_mag = opdata2_i;
      if (signed_div_i && opdata1_i[W-1]) a_mag = ~opdata1_i + W'(1);
      if (signed_div_i && opdata2_i[W-1]) b_mag = ~opdata2_i + W'(1);
   end

   // One shift-subtract step; trial[W+1] set means the subtraction went negative
   always_comb begin
      trial = work_q[2*W:W-1] - {2'b00, dvs_q};
      if (!trial[W+1]) step = {trial[W:0], work_q[W-2:0], 1'b1};
      else             step = {work_q[2*W-1:0], 1'b0};
      quot = qneg_q ? (~step[W-1:0] + W'(1)) : step[W-1:0];
      rem  = rneg_q ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         S_IDLE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  state_d = S_ON;
                  cnt_d   = '0;
                  work_d  = {(W+1)'(0), a_mag};
                  dvs_d   = b_mag;
                  qneg_d  = signed_div_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                  rneg_d  = signed_div_i && opdata1_i[W-1];
               end
            end
         end
         S_BYZERO: begin
            state_d  = S_END;
            result_d = '0;
            ready_d  = 1'b1;
         end
         S_ON: begin
            if (annul_i) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               work_d = step;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(W - 1)) begin
                  state_d  = S_END;
                  cnt_d    = '0;
                  result_d = {rem, quot};
                  ready_d  = 1'b1;
               end
            end
         end
         S_END: begin
            if (!start_i) begin
               state_d  = S_IDLE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
